// File: rtl/lelo_temp_pkg.sv
// lelo_temp_pkg
// Shared types and constants for the low-frequency temperature measurement
// sequencer (lelo_temp_seq) and its alarm comparator (lelo_temp_alarm).
//   seq_state_t : sequencer state encoding
//   LELO_DW     : default data width for delta/result/thresholds
//   acc_width() : accumulator width needed to sum 2^n_log2 samples of dw bits
package lelo_temp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WARM  = 3'd1,
        ACCUM = 3'd2,
        DONE  = 3'd3,
        SLEEP = 3'd4
    } seq_state_t;

    localparam int LELO_DW = 8;

    function automatic int acc_width(input int dw, input int n_log2);
        return dw + n_log2;
    endfunction

endpackage

// File: rtl/lelo_temp_alarm.sv
// lelo_temp_alarm
// Registered hysteresis comparator for the over-temperature flag.
// Ports:
//   lf_clk  in  clock
//   rst_n   in  synchronous active-low reset
//   upd     in  evaluate value against thresholds this cycle
//   value   in  code to compare
//   thr_hi  in  set threshold   (value >= thr_hi sets the alarm)
//   thr_lo  in  clear threshold (value <= thr_lo clears the alarm)
//   alarm   out registered alarm flag
module lelo_temp_alarm
    import lelo_temp_pkg::*;
#(
    parameter int DW = LELO_DW
) (
    input  logic          lf_clk,
    input  logic          rst_n,
    input  logic          upd,
    input  logic [DW-1:0] value,
    input  logic [DW-1:0] thr_hi,
    input  logic [DW-1:0] thr_lo,
    output logic          alarm
);

    logic r_alarm;

    // Set is tested first so it wins when thr_lo >= thr_hi.
    always_ff @(posedge lf_clk) begin
        if (!rst_n) begin
            r_alarm <= 1'b0;
        end else if (upd) begin
            if (value >= thr_hi) begin
                r_alarm <= 1'b1;
            end else if (value <= thr_lo) begin
                r_alarm <= 1'b0;
            end
        end
    end

    assign alarm = r_alarm;

endmodule

// File: rtl/lelo_temp_seq.sv
// lelo_temp_seq
// Measurement sequencer/averager around temp_osc_measure. Enables the
// oscillator, discards the first (possibly partial) window, averages
// 2^N_LOG2 windows into one code and drives a hysteretic alarm. In
// continuous mode the oscillator is kept off for sleep_cycles between runs.
// Ports:
//   lf_clk        in  32768 Hz clock
//   rst_n         in  synchronous active-low reset
//   start         in  single-shot request (only looked at in IDLE)
//   cont          in  continuous mode level
//   sleep_cycles  in  off-time between continuous measurements
//   thr_hi/thr_lo in  alarm set/clear thresholds
//   delta         in  window count
//   delta_valid   in  window-complete flag (rising edge is used)
//   ana_en        out oscillator enable
//   busy          out high whenever not IDLE
//   result        out averaged code, held between updates
//   result_valid  out one-cycle pulse on result update
//   alarm         out over-temperature flag
module lelo_temp_seq
    import lelo_temp_pkg::*;
#(
    parameter int DW      = LELO_DW,
    parameter int N_LOG2  = 2,
    parameter int SLEEP_W = 8
) (
    input  logic               lf_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    input  logic [SLEEP_W-1:0] sleep_cycles,
    input  logic [DW-1:0]      thr_hi,
    input  logic [DW-1:0]      thr_lo,
    input  logic [DW-1:0]      delta,
    input  logic               delta_valid,
    output logic               ana_en,
    output logic               busy,
    output logic [DW-1:0]      result,
    output logic               result_valid,
    output logic               alarm
);

    localparam int AW = acc_width(DW, N_LOG2);
    localparam int CW = N_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << N_LOG2) - 1);

    seq_state_t         r_state;
    logic               r_dv_q;
    logic               r_ana_en;
    logic               r_busy;
    logic [DW-1:0]      r_result;
    logic               r_result_valid;
    logic [AW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic [SLEEP_W-1:0] r_sleep_cnt;

    logic               w_dv_rise;
    logic [AW-1:0]      w_acc_sum;
    logic               w_done;

    assign w_dv_rise = delta_valid & ~r_dv_q;
    assign w_acc_sum = r_acc + AW'(delta);
    assign w_done    = (r_state == DONE);

    // Outputs are registered alongside the state so ana_en/busy/result_valid
    // change on the same edge as the state they describe.
    always_ff @(posedge lf_clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_dv_q         <= 1'b0;
            r_ana_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_sleep_cnt    <= '0;
        end else begin
            r_dv_q         <= delta_valid;
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start || cont) begin
                        r_state  <= WARM;
                        r_ana_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                WARM: begin
                    // First window after enabling may be partial: drop it.
                    if (w_dv_rise) begin
                        r_state <= ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (w_dv_rise) begin
                        if (r_cnt == CNT_LAST) begin
                            // Last sample is folded straight into the result.
                            r_state        <= DONE;
                            r_result       <= w_acc_sum[AW-1:N_LOG2];
                            r_result_valid <= 1'b1;
                            r_ana_en       <= 1'b0;
                        end else begin
                            r_acc <= w_acc_sum;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!cont) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (sleep_cycles == '0) begin
                        r_state  <= WARM;
                        r_ana_en <= 1'b1;
                    end else begin
                        r_state     <= SLEEP;
                        r_sleep_cnt <= sleep_cycles;
                    end
                end
                SLEEP: begin
                    r_sleep_cnt <= r_sleep_cnt - SLEEP_W'(1);
                    if (!cont) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_sleep_cnt == SLEEP_W'(1)) begin
                        r_state  <= WARM;
                        r_ana_en <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_ana_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Alarm is evaluated during DONE, when result already holds the new code.
    lelo_temp_alarm #(
        .DW(DW)
    ) u_alarm (
        .lf_clk (lf_clk),
        .rst_n  (rst_n),
        .upd    (w_done),
        .value  (r_result),
        .thr_hi (thr_hi),
        .thr_lo (thr_lo),
        .alarm  (alarm)
    );

    assign ana_en       = r_ana_en;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_lelo_temp_seq.sv
`timescale 1ns/1ps
module tb_lelo_temp_seq;

    logic       lf_clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic [7:0] sleep_cycles;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic [7:0] delta;
    logic       delta_valid;
    logic       ana_en;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       alarm;

    lelo_temp_seq #(
        .DW(8),
        .N_LOG2(2),
        .SLEEP_W(8)
    ) dut (
        .lf_clk       (lf_clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .sleep_cycles (sleep_cycles),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .delta        (delta),
        .delta_valid  (delta_valid),
        .ana_en       (ana_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .alarm        (alarm)
    );

    initial lf_clk = 1'b0;
    always #5 lf_clk = ~lf_clk;

    typedef struct {
        logic [7:0] res;
        logic       alm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge lf_clk);
        #1;
    endtask

    // One window: rising edge of delta_valid, then low for a cycle.
    task automatic win(input logic [7:0] v);
        delta       = v;
        delta_valid = 1'b1;
        tick();
        delta_valid = 1'b0;
        tick();
    endtask

    // Final window: returns just after the edge that enters DONE.
    task automatic last_win(input logic [7:0] v);
        delta       = v;
        delta_valid = 1'b1;
        tick();
        delta_valid = 1'b0;
    endtask

    // Discarded warm-up window followed by four averaged windows.
    task automatic measure(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [7:0] exp_res, input logic exp_alm);
        q.push_back('{res: exp_res, alm: exp_alm});
        win(8'd9);
        win(d0);
        win(d1);
        win(d2);
        last_win(d3);
    endtask

    task automatic single_shot(input logic [7:0] v, input logic exp_alm);
        start = 1'b1;
        tick();
        start = 1'b0;
        measure(v, v, v, v, v, exp_alm);
        tick();
        tick();
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (ana_en == 1'b0 && n < 50) begin
            n++;
            tick();
        end
    endtask

    // Monitor: every result_valid must match the next queued expectation;
    // the alarm is checked on the following cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge lf_clk);
            if (result_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_result_valid", 32'(result_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("ana_en_in_done", 32'(ana_en), 32'd0);
                    @(negedge lf_clk);
                    chk("alarm", 32'(alarm), 32'(e.alm));
                    chk("result_valid_pulse", 32'(result_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        start        = 1'b0;
        cont         = 1'b0;
        sleep_cycles = 8'd0;
        thr_hi       = 8'd120;
        thr_lo       = 8'd110;
        delta        = 8'd0;
        delta_valid  = 1'b0;
        tick();
        tick();
        chk("rst_ana_en", 32'(ana_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single shot: (100+101+102+104)/4 = 101
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ana_en", 32'(ana_en), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        measure(8'd100, 8'd101, 8'd102, 8'd104, 8'd101, 1'b0);
        chk("done_busy", 32'(busy), 32'd1);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ana_en", 32'(ana_en), 32'd0);
        tick();

        // Hysteresis thr_hi=120 thr_lo=110
        single_shot(8'd115, 1'b0);
        single_shot(8'd121, 1'b1);
        single_shot(8'd115, 1'b1);
        single_shot(8'd110, 1'b0);
        single_shot(8'd115, 1'b0);

        // Continuous, sleep 5 -> 6 cycles off
        cont         = 1'b1;
        sleep_cycles = 8'd5;
        tick();
        measure(8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 1'b0);
        count_low(n);
        chk("off_time_sleep5", 32'(n), 32'd6);
        measure(8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 1'b0);
        sleep_cycles = 8'd0;
        count_low(n);
        chk("off_time_sleep0", 32'(n), 32'd1);

        // cont dropped mid-ACCUM: result still completes, then IDLE
        q.push_back('{res: 8'd70, alm: 1'b0});
        win(8'd9);
        win(8'd70);
        cont = 1'b0;
        win(8'd70);
        win(8'd70);
        last_win(8'd70);
        tick();
        chk("contdrop_busy", 32'(busy), 32'd0);
        chk("contdrop_ana_en", 32'(ana_en), 32'd0);
        tick();

        // cont dropped in SLEEP
        sleep_cycles = 8'd5;
        cont         = 1'b1;
        tick();
        measure(8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 1'b0);
        tick();
        tick();
        chk("sleep_busy", 32'(busy), 32'd1);
        cont = 1'b0;
        tick();
        chk("sleepcancel_busy", 32'(busy), 32'd0);
        chk("sleepcancel_ana_en", 32'(ana_en), 32'd0);
        tick();

        // Reset mid-ACCUM with delta_valid held high
        start = 1'b1;
        tick();
        start = 1'b0;
        win(8'd9);
        win(8'd100);
        win(8'd100);
        delta       = 8'd200;
        delta_valid = 1'b1;
        rst_n       = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_ana_en", 32'(ana_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_result_valid", 32'(result_valid), 32'd0);
        chk("abort_alarm", 32'(alarm), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("held_dv_warm_busy", 32'(busy), 32'd1);
        delta_valid = 1'b0;
        tick();
        // (40+40+40+44)/4 = 41
        measure(8'd40, 8'd40, 8'd40, 8'd44, 8'd41, 1'b0);
        tick();
        tick();

        // delta_valid toggling in IDLE must not start anything
        for (int i = 0; i < 3; i++) begin
            delta       = 8'd33;
            delta_valid = 1'b1;
            tick();
            chk("idle_dv_busy", 32'(busy), 32'd0);
            delta_valid = 1'b0;
            tick();
            chk("idle_dv_ana_en", 32'(ana_en), 32'd0);
        end

        // start held while busy, max code 255 x4 -> 255
        q.push_back('{res: 8'd255, alm: 1'b1});
        start = 1'b1;
        tick();
        win(8'd9);
        win(8'd255);
        win(8'd255);
        start = 1'b0;
        win(8'd255);
        last_win(8'd255);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("no_extra_busy", 32'(busy), 32'd0);
            tick();
        end

        tick();
        tick();
        chk("pending_results", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
